// File: rtl/aurora_link_ctrl.sv
// Bring-up sequencer for one Aurora lane pair: settle, PRBS BIST qualification,
// traffic gating, teardown on channel loss/hard error, retry limit and status counters.
module aurora_link_ctrl #(
    parameter int         SETTLE_CYCLES = 256,
    parameter int         LOCK_TIMEOUT  = 4096,
    parameter int         BIST_CYCLES   = 512,
    parameter int         DRAIN_CYCLES  = 256,
    parameter int         MIN_SAMPS     = 256,
    parameter logic [4:0] BIST_RATE     = 5'd0,
    parameter int         MAX_RETRIES   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        clear_fault,
    input  logic        channel_up,
    input  logic        hard_err,
    input  logic        bist_checker_locked,
    input  logic [47:0] bist_checker_samps,
    input  logic [47:0] bist_checker_errors,
    output logic        bist_gen_en,
    output logic        bist_checker_en,
    output logic [4:0]  bist_gen_rate,
    output logic        traffic_en,
    output logic        link_ready,
    output logic        fault,
    output logic [2:0]  state_o,
    output logic [15:0] retrain_count,
    output logic [15:0] bist_fail_count
);

    localparam int MAX_A = (SETTLE_CYCLES > LOCK_TIMEOUT) ? SETTLE_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_B = (BIST_CYCLES > DRAIN_CYCLES) ? BIST_CYCLES : DRAIN_CYCLES;
    localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_T) + 1;
    localparam int RW    = $clog2(MAX_RETRIES + 1);

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] RUN_LAST    = CW'(BIST_CYCLES - 1);
    localparam logic [CW-1:0] DRAIN_LAST  = CW'(DRAIN_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LAST  = RW'(MAX_RETRIES - 1);
    localparam logic [47:0]   SAMPS_MIN   = 48'(MIN_SAMPS);

    typedef enum logic [2:0] {
        DOWN       = 3'd0,
        SETTLE     = 3'd1,
        BIST_LOCK  = 3'd2,
        BIST_RUN   = 3'd3,
        BIST_DRAIN = 3'd4,
        CHECK      = 3'd5,
        UP         = 3'd6,
        FAULT      = 3'd7
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [RW-1:0] retries;
    logic [47:0]   samps_q;
    logic [47:0]   errors_q;

    logic abort;
    logic check_pass;
    logic fail_now;
    logic last_retry;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign abort      = !channel_up || hard_err || !enable;
    assign check_pass = (errors_q == 48'd0) && (samps_q > SAMPS_MIN);
    assign last_retry = (retries == RETRY_LAST);
    // Lock timeout and a failed CHECK share one failure path.
    assign fail_now   = ((state == BIST_LOCK) && !bist_checker_locked && (cnt == LOCK_LAST)) ||
                        ((state == CHECK) && !check_pass);
    assign state_o    = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= DOWN;
            cnt             <= '0;
            retries         <= '0;
            samps_q         <= '0;
            errors_q        <= '0;
            bist_gen_en     <= 1'b0;
            bist_checker_en <= 1'b0;
            bist_gen_rate   <= 5'd0;
            traffic_en      <= 1'b0;
            link_ready      <= 1'b0;
            fault           <= 1'b0;
            retrain_count   <= 16'd0;
            bist_fail_count <= 16'd0;
        end else if ((state != FAULT) && abort) begin
            // Abort preempts everything outside FAULT; only a lost UP link counts as a retrain.
            state           <= DOWN;
            cnt             <= '0;
            bist_gen_en     <= 1'b0;
            bist_checker_en <= 1'b0;
            bist_gen_rate   <= 5'd0;
            traffic_en      <= 1'b0;
            link_ready      <= 1'b0;
            if (state == UP) begin
                retrain_count <= sat_inc16(retrain_count);
            end
        end else if (fail_now) begin
            state           <= last_retry ? FAULT : DOWN;
            fault           <= last_retry;
            cnt             <= '0;
            retries         <= retries + RW'(1);
            bist_gen_en     <= 1'b0;
            bist_checker_en <= 1'b0;
            bist_gen_rate   <= 5'd0;
            bist_fail_count <= sat_inc16(bist_fail_count);
        end else begin
            case (state)
                DOWN: begin
                    state <= SETTLE;
                    cnt   <= '0;
                end
                SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        state           <= BIST_LOCK;
                        cnt             <= '0;
                        bist_gen_en     <= 1'b1;
                        bist_checker_en <= 1'b1;
                        bist_gen_rate   <= BIST_RATE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                BIST_LOCK: begin
                    if (bist_checker_locked) begin
                        state <= BIST_RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                BIST_RUN: begin
                    if (cnt == RUN_LAST) begin
                        state         <= BIST_DRAIN;
                        cnt           <= '0;
                        samps_q       <= bist_checker_samps;
                        errors_q      <= bist_checker_errors;
                        bist_gen_en   <= 1'b0;
                        bist_gen_rate <= 5'd0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                BIST_DRAIN: begin
                    if (cnt == DRAIN_LAST) begin
                        state           <= CHECK;
                        cnt             <= '0;
                        bist_checker_en <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                CHECK: begin
                    state      <= UP;
                    retries    <= '0;
                    traffic_en <= 1'b1;
                    link_ready <= 1'b1;
                end
                UP: begin
                    state <= UP;
                end
                FAULT: begin
                    if (clear_fault) begin
                        state   <= DOWN;
                        fault   <= 1'b0;
                        retries <= '0;
                    end
                end
                default: begin
                    state <= DOWN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aurora_link_ctrl.sv
// Directed bench for aurora_link_ctrl: bring-up, settle glitch, lock timeouts to FAULT,
// CHECK failures and retry reset, hard-error teardown, async reset mid-BIST.
module tb_aurora_link_ctrl;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        clear_fault;
    logic        channel_up;
    logic        hard_err;
    logic        bist_checker_locked;
    logic [47:0] bist_checker_samps;
    logic [47:0] bist_checker_errors;
    logic        bist_gen_en;
    logic        bist_checker_en;
    logic [4:0]  bist_gen_rate;
    logic        traffic_en;
    logic        link_ready;
    logic        fault;
    logic [2:0]  state_o;
    logic [15:0] retrain_count;
    logic [15:0] bist_fail_count;

    int checks = 0;
    int errors = 0;

    aurora_link_ctrl dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .enable              (enable),
        .clear_fault         (clear_fault),
        .channel_up          (channel_up),
        .hard_err            (hard_err),
        .bist_checker_locked (bist_checker_locked),
        .bist_checker_samps  (bist_checker_samps),
        .bist_checker_errors (bist_checker_errors),
        .bist_gen_en         (bist_gen_en),
        .bist_checker_en     (bist_checker_en),
        .bist_gen_rate       (bist_gen_rate),
        .traffic_en          (traffic_en),
        .link_ready          (link_ready),
        .fault               (fault),
        .state_o             (state_o),
        .retrain_count       (retrain_count),
        .bist_fail_count     (bist_fail_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n               = 1'b0;
        enable              = 1'b0;
        clear_fault         = 1'b0;
        channel_up          = 1'b0;
        hard_err            = 1'b0;
        bist_checker_locked = 1'b0;
        bist_checker_samps  = 48'd0;
        bist_checker_errors = 48'd0;
        cyc(2);
        chk("rst_state", state_o, 0);
        chk("rst_gen_en", bist_gen_en, 0);
        chk("rst_link_ready", link_ready, 0);
        chk("rst_fail_count", bist_fail_count, 0);

        // T1: clean bring-up
        enable              = 1'b1;
        channel_up          = 1'b1;
        bist_checker_locked = 1'b1;
        bist_checker_samps  = 48'd1000;
        rst_n               = 1'b1;
        cyc(1);
        chk("t1_settle", state_o, 1);
        cyc(255);
        chk("t1_settle_end_state", state_o, 1);
        chk("t1_settle_end_gen", bist_gen_en, 0);
        cyc(1);
        chk("t1_lock_state", state_o, 2);
        chk("t1_lock_gen", bist_gen_en, 1);
        chk("t1_lock_chk", bist_checker_en, 1);
        chk("t1_lock_rate", bist_gen_rate, 0);
        cyc(1);
        chk("t1_run", state_o, 3);
        cyc(512);
        chk("t1_drain_state", state_o, 4);
        chk("t1_drain_gen", bist_gen_en, 0);
        chk("t1_drain_chk", bist_checker_en, 1);
        cyc(256);
        chk("t1_check_state", state_o, 5);
        chk("t1_check_chk", bist_checker_en, 0);
        chk("t1_check_ready", link_ready, 0);
        cyc(1);
        chk("t1_up_state", state_o, 6);
        chk("t1_up_ready", link_ready, 1);
        chk("t1_up_traffic", traffic_en, 1);

        // T5: one-cycle hard error in UP
        hard_err = 1'b1;
        cyc(1);
        hard_err = 1'b0;
        chk("t5_state", state_o, 0);
        chk("t5_traffic", traffic_en, 0);
        chk("t5_retrain", retrain_count, 1);
        cyc(1);
        chk("t5_resettle", state_o, 1);
        cyc(1026);
        chk("t5_relink", state_o, 6);
        chk("t5_fail_count", bist_fail_count, 0);

        // T2: channel_up glitch at SETTLE cycle 100
        channel_up = 1'b0;
        cyc(1);
        chk("t2_drop_retrain", retrain_count, 2);
        channel_up = 1'b1;
        cyc(1);
        cyc(100);
        chk("t2_in_settle", state_o, 1);
        channel_up = 1'b0;
        cyc(1);
        chk("t2_glitch_down", state_o, 0);
        channel_up = 1'b1;
        cyc(1);
        cyc(255);
        chk("t2_restart_state", state_o, 1);
        chk("t2_restart_gen", bist_gen_en, 0);
        cyc(1);
        chk("t2_lock", state_o, 2);
        chk("t2_retrain", retrain_count, 2);
        chk("t2_fail_count", bist_fail_count, 0);

        // T3: checker never locks, three timeouts to FAULT
        bist_checker_locked = 1'b0;
        cyc(4095);
        chk("t3_lock_hold", state_o, 2);
        cyc(1);
        chk("t3_to1_state", state_o, 0);
        chk("t3_to1_gen", bist_gen_en, 0);
        chk("t3_to1_chk", bist_checker_en, 0);
        chk("t3_to1_count", bist_fail_count, 1);
        cyc(257);
        chk("t3_lock2", state_o, 2);
        cyc(4096);
        chk("t3_to2_state", state_o, 0);
        chk("t3_to2_count", bist_fail_count, 2);
        cyc(257);
        cyc(4096);
        chk("t3_fault_state", state_o, 7);
        chk("t3_fault", fault, 1);
        chk("t3_fault_count", bist_fail_count, 3);
        enable = 1'b0;
        cyc(5);
        chk("t3_sticky_state", state_o, 7);
        chk("t3_sticky_fault", fault, 1);
        enable      = 1'b1;
        hard_err    = 1'b1;
        clear_fault = 1'b1;
        cyc(1);
        clear_fault = 1'b0;
        hard_err    = 1'b0;
        chk("t3_clear_state", state_o, 0);
        chk("t3_clear_fault", fault, 0);
        bist_checker_locked = 1'b1;
        cyc(1);
        cyc(1026);
        chk("t3_requal", state_o, 6);

        // T4: errors at end of RUN fail CHECK
        channel_up = 1'b0;
        cyc(1);
        chk("t4_retrain", retrain_count, 3);
        channel_up = 1'b1;
        cyc(1);
        cyc(256);
        cyc(1);
        cyc(511);
        chk("t4_run", state_o, 3);
        bist_checker_errors = 48'd5;
        cyc(1);
        bist_checker_errors = 48'd0;
        chk("t4_drain", state_o, 4);
        cyc(256);
        chk("t4_check", state_o, 5);
        cyc(1);
        chk("t4_fail_state", state_o, 0);
        chk("t4_fail_count", bist_fail_count, 4);
        chk("t4_no_fault", fault, 0);
        chk("t4_no_ready", link_ready, 0);
        cyc(1);
        cyc(1026);
        chk("t4_pass", state_o, 6);

        // Two more failures after a pass must not reach FAULT; samps==MIN_SAMPS fails
        channel_up = 1'b0;
        cyc(1);
        chk("t4_retrain2", retrain_count, 4);
        channel_up         = 1'b1;
        bist_checker_samps = 48'd256;
        cyc(1);
        cyc(1026);
        chk("t4_samps_min_state", state_o, 0);
        chk("t4_samps_min_count", bist_fail_count, 5);
        bist_checker_samps  = 48'd1000;
        bist_checker_errors = 48'd5;
        cyc(1);
        cyc(1026);
        chk("t4_err2_state", state_o, 0);
        chk("t4_err2_fault", fault, 0);
        chk("t4_err2_count", bist_fail_count, 6);
        bist_checker_errors = 48'd0;
        bist_checker_samps  = 48'd257;
        cyc(1);
        cyc(1026);
        chk("t4_samps_min1_pass", state_o, 6);

        // T6: async reset mid BIST_RUN
        channel_up = 1'b0;
        cyc(1);
        chk("t6_retrain", retrain_count, 5);
        channel_up = 1'b1;
        cyc(1);
        cyc(256);
        cyc(1);
        cyc(100);
        chk("t6_run_state", state_o, 3);
        chk("t6_run_gen", bist_gen_en, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_state", state_o, 0);
        chk("t6_gen", bist_gen_en, 0);
        chk("t6_chk", bist_checker_en, 0);
        chk("t6_retrain0", retrain_count, 0);
        chk("t6_fail0", bist_fail_count, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        chk("t6_restart", state_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
